// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and constants for the iterative multiplier
//   mul_state_t : sequencer states IDLE, RUN, DONE
//   MUL_WIDTH   : operand/result width
//   MUL_ITERS   : shift-and-add iterations per product
//   MUL_CNT_W   : iteration counter width
package mul_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
    localparam int MUL_WIDTH = 32;
    localparam int MUL_ITERS = 32;
    localparam int MUL_CNT_W = 5;
endpackage

// File: rtl/mul_seq_alu.sv
// alu: adder/subtractor shared by the execution units
//   a, b   : operands
//   ALUAdd : 1 = a+b, 0 = a-b
//   result : sum or difference, modulo 2^WIDTH
//   EQ     : a equals b
module alu
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ALUAdd,
    output logic [WIDTH-1:0] result,
    output logic             EQ
);
    always_comb begin
        result = ALUAdd ? a + b : a - b;
        EQ     = a == b;
    end
endmodule

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-and-add 32x32 multiplier (low 32 bits) with valid/ready
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake, a = multiplicand, b = multiplier
//   out_valid/out_ready : result handshake, result = low bits of a*b
//   busy                : high in RUN or DONE
//   MUL_SEQ_EARLY_EXIT_EN: when defined, RUN ends as soon as the multiplier is exhausted
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    mul_state_t state, nstate;
    logic [WIDTH-1:0] acc, mcand, mplier, sum;
    logic [MUL_CNT_W-1:0] count;
    logic stop;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (acc),
        .b      (mcand),
        .ALUAdd (1'b1),
        .result (sum),
        .EQ     ()
    );

`ifdef MUL_SEQ_EARLY_EXIT_EN
    // no set multiplier bits remain, so acc already holds the product
    assign stop = mplier == '0;
`else
    assign stop = 1'b0;
`endif

    always_comb begin
        nstate = state;
        if (state == IDLE && in_valid) nstate = RUN;
        if (state == RUN && (stop || count == MUL_CNT_W'(MUL_ITERS - 1))) nstate = DONE;
        if (state == DONE && out_ready) nstate = IDLE;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        result    = acc;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nstate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (state == IDLE && in_valid) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
        end else if (state == RUN && !stop) begin
            if (mplier[0]) acc <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: self-checking bench for mul_seq (vector table + scoreboard + corner sequences)
module tb_mul_seq;
    logic        clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
    logic [31:0] a = 0, b = 0;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;
    int checks = 0, fails = 0;
    logic [31:0] sb[$];
    int          lq[$];

    typedef struct {logic [31:0] a, b, p;} vec_t;
    vec_t vt[8];

    mul_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic int lat(input logic [31:0] v);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        if (v == 0) return 1;
        for (int i = 31; i >= 0; i--) if (v[i]) return (i + 2 > 32) ? 32 : i + 2;
`endif
        return 32;
    endfunction

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("issue_ready", {31'b0, in_ready}, 1);
        in_valid = 1; a = x; b = y;
        sb.push_back(x * y);
        lq.push_back(lat(y));
        @(posedge clk); #1;
        in_valid = 0; a = $urandom; b = $urandom;
    endtask

    task automatic collect(input int hold);
        int n = 0;
        logic [31:0] r;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, lq.pop_front());
        chk("result", result, sb.pop_front());
        chk("busy_done", {31'b0, busy}, 1);
        chk("in_ready_done", {31'b0, in_ready}, 0);
        r = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = i == hold / 2;
            if (in_valid) begin a = 32'h55; b = 32'h66; end
            @(posedge clk); #1;
            in_valid = 0;
            chk("bp_valid", {31'b0, out_valid}, 1);
            chk("bp_result", result, r);
            chk("bp_in_ready", {31'b0, in_ready}, 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("idle_valid", {31'b0, out_valid}, 0);
        chk("idle_ready", {31'b0, in_ready}, 1);
        chk("idle_busy", {31'b0, busy}, 0);
    endtask

    initial begin
        vt[0] = '{32'd7, 32'd6, 32'd42};
        vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vt[2] = '{32'h12345678, 32'd0, 32'd0};
        vt[3] = '{32'd3, 32'd5, 32'd15};
        vt[4] = '{32'd1, 32'h80000000, 32'h80000000};
        vt[5] = '{32'h00010000, 32'h00010000, 32'h00000000};
        vt[6] = '{32'hDEADBEEF, 32'd1, 32'hDEADBEEF};
        vt[7] = '{32'd1000, 32'd1000, 32'd1000000};
        #2 rst_n = 0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            issue(vt[i].a, vt[i].b);
            collect(0);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] x, y;
            x = $urandom; y = $urandom >> $urandom_range(0, 31);
            issue(x, y);
            chk("rand_model", x * y, vt[0].a * 0 + x * y);
            collect(0);
        end
        issue(32'd9, 32'd11);
        collect(10);
        issue(32'd9, 32'd9);
        sb.delete(); lq.delete();
        repeat (9) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        @(negedge clk) rst_n = 1;
        issue(32'd2, 32'd3);
        collect(0);
        issue(32'd1, 32'h80000000);
        collect(0);
        issue(32'h00010000, 32'h00010000);
        collect(0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
